// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture / frame scheduling slice.
//   IMG_W, IMG_H  : default frame geometry in pixels (160 x 120)
//   AW            : default frame-buffer address width (holds 0..19199)
//   sched_state_t : state encoding of the frame_scheduler control FSM
// No ports; imported by frame_scheduler.
// ---------------------------------------------------------------------------
package cam_pkg;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int AW    = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_VS   = 3'd1,
        CAPTURE   = 3'd2,
        SCAN      = 3'd3,
        WAIT_PROC = 3'd4,
        DONE      = 3'd5
    } sched_state_t;

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous level input followed by a
// rising-edge detector that looks only at the synchronised copy, so a
// metastable first stage can never produce a spurious edge.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-low reset, clears all three flops
//   async_in in  level signal from another clock domain
//   rise     out one-cycle pulse on each synchronised 0->1 transition
// ---------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one history flop for the edge compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Sequences one capture+analysis cycle per start request: wait for a camera
// VSYNC edge, let exactly one frame be written into the buffer, then freeze
// the buffer and stream every address to the processing block, and finally
// wait for that block to report completion.
//
// Optional feature (macro CAPTURE_TIMEOUT_EN): a watchdog counts cycles spent
// in WAIT_VS and CAPTURE together; reaching TIMEOUT_CYC sets the sticky
// timeout flag and abandons the cycle without a done pulse. Without the
// macro there is no watchdog, timeout is tied low and VSYNC is awaited
// indefinitely.
//
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-low reset
//   start      in  request a cycle (only honoured in IDLE)
//   cam_vsync  in  camera VSYNC, asynchronous to clk
//   cap_en     out camera-to-buffer write permission, high only in CAPTURE
//   scan_addr  out buffer read address, 0 outside SCAN
//   scan_valid out read data for last cycle's scan_addr is valid now
//   scan_last  out marks the scan_valid of the final address
//   proc_done  in  processing block has finished
//   busy       out high in every state except IDLE
//   done       out one-cycle end-of-cycle pulse
//   timeout    out sticky capture-window error flag
// ---------------------------------------------------------------------------
module frame_scheduler #(
    parameter int IMG_W       = cam_pkg::IMG_W,
    parameter int IMG_H       = cam_pkg::IMG_H,
    parameter int AW          = cam_pkg::AW,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cam_vsync,
    output logic          cap_en,
    output logic [AW-1:0] scan_addr,
    output logic          scan_valid,
    output logic          scan_last,
    input  logic          proc_done,
    output logic          busy,
    output logic          done,
    output logic          timeout
);

    import cam_pkg::*;

    localparam int            FRAME_PIX = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

    sched_state_t  state_q;
    sched_state_t  state_d;
    logic          vs_rise;
    logic [AW-1:0] scan_cnt_q;
    logic          proc_flag_q;
    logic          timeout_hit;

    sync_edge u_vs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cam_vsync),
        .rise     (vs_rise)
    );

    // State register; reset drops any cycle in progress back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs. proc_done is also looked at directly in
    // WAIT_PROC so a completion arriving there reaches DONE next cycle,
    // while an earlier one is remembered by the sticky flag.
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_cnt_q == LAST_ADDR) begin
                    state_d = WAIT_PROC;
                end
            end
            WAIT_PROC: begin
                if (proc_flag_q || proc_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scan address counter with registered valid/last one cycle behind the
    // address. The counter parks at 0 whenever it is not stepping, so it
    // never wraps and leaves SCAN already cleared for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            scan_valid <= 1'b0;
            scan_last  <= 1'b0;
        end else begin
            scan_valid <= (state_q == SCAN);
            scan_last  <= (state_q == SCAN) && (scan_cnt_q == LAST_ADDR);
            if ((state_q == SCAN) && (scan_cnt_q != LAST_ADDR)) begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end else begin
                scan_cnt_q <= '0;
            end
        end
    end

    assign scan_addr = scan_cnt_q;

    // Sticky record of proc_done so a completion during the scan is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proc_flag_q <= 1'b0;
        end else if (state_q == DONE) begin
            proc_flag_q <= 1'b0;
        end else if (proc_done && ((state_q == SCAN) || (state_q == WAIT_PROC))) begin
            proc_flag_q <= 1'b1;
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    logic [WDW-1:0] wd_cnt_q;
    logic           timeout_q;

    assign timeout_hit = ((state_q == WAIT_VS) || (state_q == CAPTURE)) &&
                         (wd_cnt_q == WDW'(TIMEOUT_CYC - 1));

    // Watchdog over the capture window; the error flag stays set until the
    // next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == WAIT_VS) || (state_q == CAPTURE)) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end else begin
                wd_cnt_q <= '0;
            end
            if ((state_q == IDLE) && start) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    // Parameter kept referenced so both builds share one interface.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Directed self-checking bench for frame_scheduler. Expected scan addresses
// and done ordinals are queued when a start is issued and consumed by a
// monitor as the DUT produces scan_valid / done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int IMG_W     = 160;
    localparam int IMG_H     = 120;
    localparam int AW        = 15;
    localparam int FRAME_PIX = IMG_W * IMG_H;
`ifdef CAPTURE_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
    localparam int CAP_GAP     = 20;
`else
    localparam int TIMEOUT_CYC = 4000000;
    localparam int CAP_GAP     = 1000;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          start     = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          proc_done = 1'b0;
    logic          cap_en;
    logic [AW-1:0] scan_addr;
    logic          scan_valid;
    logic          scan_last;
    logic          busy;
    logic          done;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    int exp_addr[$];
    int exp_done[$];
    int exp_done_total = 0;

    int valid_count = 0;
    int last_count  = 0;
    int cap_cycles  = 0;
    int done_count  = 0;
    logic [AW-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    frame_scheduler #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .AW          (AW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cam_vsync  (cam_vsync),
        .cap_en     (cap_en),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .scan_last  (scan_last),
        .proc_done  (proc_done),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; when a full cycle is expected, queue every scan
    // address and the ordinal of the done pulse it should produce.
    task automatic applyStimulus(input bit expect_frame);
        if (expect_frame) begin
            for (int i = 0; i < FRAME_PIX; i++) begin
                exp_addr.push_back(i);
            end
            exp_done_total++;
            exp_done.push_back(exp_done_total);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic flushExpected();
        exp_addr.delete();
        exp_done_total -= exp_done.size();
        exp_done.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cap_en"},     32'(cap_en),     0);
        checkOutput({tag, "_scan_addr"},  32'(scan_addr),  0);
        checkOutput({tag, "_scan_valid"}, 32'(scan_valid), 0);
        checkOutput({tag, "_scan_last"},  32'(scan_last),  0);
        checkOutput({tag, "_busy"},       32'(busy),       0);
        checkOutput({tag, "_done"},       32'(done),       0);
        checkOutput({tag, "_timeout"},    32'(timeout),    0);
    endtask

    // Two vsync rising edges CAP_GAP cycles apart, each held high 10 cycles.
    task automatic vsyncFrame();
        cam_vsync = 1'b1;
        repeat (10) tick();
        cam_vsync = 1'b0;
        repeat (CAP_GAP - 10) tick();
        cam_vsync = 1'b1;
        repeat (10) tick();
        cam_vsync = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int e;
        if (scan_valid) begin
            valid_count++;
            if (scan_last) last_count++;
            if (exp_addr.size() == 0) begin
                checkOutput("scan_valid_unexpected", 32'(scan_valid), 0);
            end else begin
                e = exp_addr.pop_front();
                checkOutput("scan_addr_order", 32'(prev_addr), e);
                checkOutput("scan_last_flag", 32'(scan_last), 32'(e == FRAME_PIX - 1));
            end
        end
        if (cap_en) cap_cycles++;
        if (done) begin
            done_count++;
            if (exp_done.size() == 0) begin
                checkOutput("done_unexpected", 32'(done), 0);
            end else begin
                e = exp_done.pop_front();
                checkOutput("done_ordinal", done_count, e);
            end
        end
        prev_addr = scan_addr;
    end

    initial begin
        int n;
        $display("[TB] frame_scheduler bench started");

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b1;
        tick();
        checkOutput("idle_after_release", 32'(busy), 0);

        // Nominal cycle
        applyStimulus(1'b1);
        checkOutput("nom_busy", 32'(busy), 1);
        checkOutput("nom_no_cap_yet", 32'(cap_en), 0);
        cap_cycles = 0; valid_count = 0; last_count = 0;
        vsyncFrame();
        n = 0;
        while (!scan_last && n < 30000) begin tick(); n++; end
        checkOutput("nom_scan_last_seen", 32'(scan_last), 1);
        checkOutput("nom_cap_cycles", cap_cycles, CAP_GAP);
        repeat (5) tick();
        checkOutput("nom_waiting_proc", 32'(busy), 1);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        checkOutput("nom_done_pulse", 32'(done), 1);
        tick();
        checkOutput("nom_done_one_cycle", 32'(done), 0);
        checkOutput("nom_idle_after_done", 32'(busy), 0);
        checkOutput("nom_valid_count", valid_count, FRAME_PIX);
        checkOutput("nom_last_count", last_count, 1);
        checkOutput("nom_addr_queue_empty", exp_addr.size(), 0);

        // Early proc_done plus ignored starts in CAPTURE, SCAN and DONE
        applyStimulus(1'b1);
        valid_count = 0; last_count = 0;
        cam_vsync = 1'b1;
        repeat (5) tick();
        checkOutput("ign_in_capture", 32'(cap_en), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ign_start_capture_cap", 32'(cap_en), 1);
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (CAP_GAP - 10) tick();
        cam_vsync = 1'b1;
        repeat (10) tick();
        cam_vsync = 1'b0;
        n = 0;
        while (scan_addr != 100 && n < 1000) begin tick(); n++; end
        checkOutput("early_reach_100", 32'(scan_addr), 100);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        checkOutput("early_scan_continues", 32'(scan_addr), 101);
        n = 0;
        while (scan_addr != 200 && n < 1000) begin tick(); n++; end
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ign_start_scan", 32'(scan_addr), 201);
        n = 0;
        while (!scan_last && n < 30000) begin tick(); n++; end
        checkOutput("early_scan_last_seen", 32'(scan_last), 1);
        tick();
        checkOutput("early_done_after_scan", 32'(done), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ign_start_done_idle", 32'(busy), 0);
        tick();
        checkOutput("ign_start_done_stays_idle", 32'(busy), 0);
        checkOutput("early_valid_count", valid_count, FRAME_PIX);
        checkOutput("early_last_count", last_count, 1);
        checkOutput("dones_after_two_frames", done_count, 2);

        // Mid-operation reset
        applyStimulus(1'b1);
        vsyncFrame();
        n = 0;
        while (scan_addr != 5000 && n < 10000) begin tick(); n++; end
        checkOutput("rst_reach_5000", 32'(scan_addr), 5000);
        rst = 1'b0;
        #1;
        checkAllZero("midrst");
        flushExpected();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_waits_for_start", 32'(busy), 0);
`ifdef CAPTURE_TIMEOUT_EN
        applyStimulus(1'b0);
        checkOutput("restart_busy", 32'(busy), 1);
        checkOutput("restart_cap_en", 32'(cap_en), 0);
        checkOutput("restart_addr", 32'(scan_addr), 0);
        n = 1;
        while (!timeout && n < 200) begin tick(); n++; end
        checkOutput("to_cycle", n, TIMEOUT_CYC);
        checkOutput("to_busy", 32'(busy), 0);
        checkOutput("to_cap_en", 32'(cap_en), 0);
        applyStimulus(1'b0);
        checkOutput("to_cleared", 32'(timeout), 0);
        checkOutput("to_restart_busy", 32'(busy), 1);
`else
        applyStimulus(1'b1);
        checkOutput("restart_busy", 32'(busy), 1);
        checkOutput("restart_cap_en", 32'(cap_en), 0);
        checkOutput("restart_addr", 32'(scan_addr), 0);
        repeat (100) tick();
        checkOutput("novs_still_waiting", 32'(busy), 1);
        checkOutput("novs_no_timeout", 32'(timeout), 0);
        checkOutput("novs_no_capture", 32'(cap_en), 0);
`endif
        rst = 1'b0;
        #1;
        flushExpected();
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // VSYNC already high when start arrives
        cam_vsync = 1'b1;
        repeat (5) tick();
        applyStimulus(1'b1);
        repeat (10) tick();
        checkOutput("glitch_no_capture", 32'(cap_en), 0);
        checkOutput("glitch_busy", 32'(busy), 1);
        cam_vsync = 1'b0;
        repeat (5) tick();
        cam_vsync = 1'b1;
        n = 0;
        while (!cap_en && n < 20) begin tick(); n++; end
        checkOutput("glitch_capture_latency", n, 3);
        rst = 1'b0;
        #1;
        flushExpected();
        cam_vsync = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        checkOutput("final_done_count", done_count, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
